aurora_nfc_ctrl: RTL and testbench
==================================

Name: aurora_nfc_ctrl

Overview:
Native-flow-control (NFC) scheduler for one Aurora 8B10B lane on the hs_clock domain. It watches the fill level of the local RX FIFO, which is drained by the hs_i_noc_bus consumer. When the FIFO nears full, it asks the link partner to stop sending (XOFF); when the FIFO drains, it lets the partner resume (XON). Requests go to the core's NFC AXI-Stream port, so the remote hs_o_noc_bus_ready drops before the local FIFO can overflow.

Parameters:
FIFO_DEPTH, 512, depth of the monitored RX FIFO in words.
LVL_W, $clog2(FIFO_DEPTH)+1, width of the level input.
HI_WM, 384, level at or above which XOFF is issued.
LO_WM, 128, level at or below which XON is issued. Must satisfy LO_WM < HI_WM < FIFO_DEPTH; elaboration fails otherwise.
REFRESH_CYC, 1024, period in cycles for re-sending XOFF while paused.

Ports:
hs_clock  in  1  single clock for all logic.
pcie_reset_n  in  1  asynchronous, active-low reset.
channel_up  in  1  Aurora channel status.
fifo_level  in  LVL_W  current RX FIFO occupancy, synchronous to hs_clock.
force_xoff  in  1  software override; holds the remote paused while high.
clr_stats  in  1  synchronous one-cycle pulse; clears xoff_cnt.
nfc_tvalid  out  1  NFC request valid.
nfc_tready  in  1  NFC request accepted by the core.
nfc_tdata  out  8  [4] = XOFF flag, [3:0] = NB pause count (always 0), [7:5] = 0.
remote_paused  out  1  high while the partner is held off.
xoff_cnt  out  16  saturating count of accepted XOFF requests.
state_o  out  3  current FSM state, for debug.

Behaviour:
- Reset (async assert, sync deassert handled upstream): state = LINK_DOWN, nfc_tvalid = 0, nfc_tdata = 0, remote_paused = 0, xoff_cnt = 0, refresh timer = 0.
- All outputs are registered. A threshold crossing at edge N makes nfc_tvalid high after edge N+1 (one-cycle decision latency).
- FSM state encodings: LINK_DOWN = 0, RUN = 1, REQ_XOFF = 2, PAUSED = 3, REQ_XON = 4.
- LINK_DOWN: all outputs idle. If channel_up is sampled high, go to RUN.
- RUN: if fifo_level >= HI_WM or force_xoff, go to REQ_XOFF.
- REQ_XOFF: nfc_tvalid = 1, nfc_tdata = 8'h10. On nfc_tvalid && nfc_tready:
  - go to PAUSED;
  - xoff_cnt += 1, saturating at 16'hFFFF;
  - timer = 0.
- PAUSED: remote_paused = 1, timer += 1. Exits, in priority order:
  1. fifo_level <= LO_WM and !force_xoff: go to REQ_XON (takes priority over refresh in the same cycle).
  2. timer == REFRESH_CYC-1: go to REQ_XOFF for a refresh request.
- REQ_XON: nfc_tvalid = 1, nfc_tdata = 8'h00; remote_paused stays 1. On handshake, go to RUN and clear remote_paused.
- Handshake rules:
  - Once nfc_tvalid is asserted, nfc_tdata stays stable and nfc_tvalid stays high until nfc_tready. There is no retraction, except on link loss.
  - Level changes during REQ_XOFF or REQ_XON do not alter the pending request.
- Link loss: channel_up low in any state forces LINK_DOWN on the next edge and deasserts nfc_tvalid and remote_paused; the timer clears. This overrides every other transition. xoff_cnt is retained.
- clr_stats and an accepted XOFF in the same cycle: the result is xoff_cnt = 1.
- Hysteresis: a level between LO_WM and HI_WM causes no transition in RUN or PAUSED.
- Comparisons are unsigned LVL_W-bit. A level of FIFO_DEPTH (full) is valid and counts as >= HI_WM.

Decomposition:
- Package aurora_nfc_pkg holds:
  - the state enum (3-bit);
  - NFC_XOFF = 8'h10 and NFC_XON = 8'h00;
  - a localparam for the tdata XOFF bit index.
- A single module is used. The refresh timer and saturating counter stay inline; no sub-module is warranted.

Test Plan:
1. Reset with channel_up = 0, then raise channel_up: state_o goes 0→1, and nfc_tvalid stays 0 with fifo_level = 0.
2. Ramp fifo_level 383→384 with nfc_tready = 1: nfc_tvalid is high with tdata = 8'h10 one cycle later; then remote_paused = 1 and xoff_cnt = 1.
3. While PAUSED, drop the level to 129 and then 128: no request at 129; at 128, tvalid with tdata = 8'h00 the next cycle; after the handshake, remote_paused = 0 and state_o = 1.
4. Hold the level at 400 for 3000 cycles with nfc_tready = 1: XOFF is re-sent each REFRESH_CYC period (about 1025 cycles apart); xoff_cnt = 3 at the end.
5. Hold nfc_tready = 0 for 20 cycles during REQ_XOFF while the level falls to 0: tvalid and tdata are held at 8'h10 throughout, then accepted; the XON request follows.
6. Drop channel_up mid-REQ_XON with tready = 0: nfc_tvalid = 0 and remote_paused = 0 the next cycle, state_o = 0, and xoff_cnt is unchanged.

Source files
------------

// File: rtl/aurora_nfc_pkg.sv
// ============================================================================
// aurora_nfc_pkg: shared state encoding and NFC request codes for aurora_nfc_ctrl.
// Rev 1.0
// ============================================================================
`default_nettype none

package aurora_nfc_pkg;

    typedef enum logic [2:0] {
        LINK_DOWN = 3'd0,
        RUN       = 3'd1,
        REQ_XOFF  = 3'd2,
        PAUSED    = 3'd3,
        REQ_XON   = 3'd4
    } nfc_state_e;

    localparam int         NFC_XOFF_BIT = 4;
    localparam logic [7:0] NFC_XOFF     = 8'h10;
    localparam logic [7:0] NFC_XON      = 8'h00;

endpackage

`default_nettype wire

// File: rtl/aurora_nfc_ctrl.sv
// ============================================================================
// aurora_nfc_ctrl: issues XOFF/XON on the Aurora NFC port from RX FIFO level.
// Rev 1.0
// ============================================================================
`default_nettype none

module aurora_nfc_ctrl
    import aurora_nfc_pkg::*;
#(
    parameter int FIFO_DEPTH  = 512,
    parameter int LVL_W       = $clog2(FIFO_DEPTH) + 1,
    parameter int HI_WM       = 384,
    parameter int LO_WM       = 128,
    parameter int REFRESH_CYC = 1024
) (
    input  logic             hs_clock,
    input  logic             pcie_reset_n,
    input  logic             channel_up,
    input  logic [LVL_W-1:0] fifo_level,
    input  logic             force_xoff,
    input  logic             clr_stats,
    output logic             nfc_tvalid,
    input  logic             nfc_tready,
    output logic [7:0]       nfc_tdata,
    output logic             remote_paused,
    output logic [15:0]      xoff_cnt,
    output logic [2:0]       state_o
);

    localparam int TMR_W = $clog2(REFRESH_CYC) + 1;

    generate
        if (!((LO_WM < HI_WM) && (HI_WM < FIFO_DEPTH))) begin : g_bad_watermarks
            $error("aurora_nfc_ctrl: watermarks must satisfy LO_WM < HI_WM < FIFO_DEPTH");
        end
    endgenerate

    nfc_state_e       state_q;
    logic             tvalid_q;
    logic [7:0]       tdata_q;
    logic             paused_q;
    logic [15:0]      cnt_q;
    logic [TMR_W-1:0] timer_q;

    logic w_hi_hit;
    logic w_lo_hit;
    logic w_hs;
    logic w_refresh;
    logic [15:0] w_cnt_inc;

    assign w_hi_hit  = (fifo_level >= LVL_W'(HI_WM));
    assign w_lo_hit  = (fifo_level <= LVL_W'(LO_WM));
    assign w_hs      = tvalid_q && nfc_tready;
    assign w_refresh = (timer_q == TMR_W'(REFRESH_CYC - 1));
    assign w_cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    always_ff @(posedge hs_clock or negedge pcie_reset_n) begin
        if (!pcie_reset_n) begin
            state_q  <= LINK_DOWN;
            tvalid_q <= 1'b0;
            tdata_q  <= 8'h00;
            paused_q <= 1'b0;
            cnt_q    <= 16'h0000;
            timer_q  <= '0;
        end else begin
            if (clr_stats) begin
                cnt_q <= 16'h0000;
            end
            // Link loss withdraws any pending request; the statistics survive.
            if (!channel_up) begin
                state_q  <= LINK_DOWN;
                tvalid_q <= 1'b0;
                tdata_q  <= 8'h00;
                paused_q <= 1'b0;
                timer_q  <= '0;
            end else begin
                case (state_q)
                    LINK_DOWN: state_q <= RUN;
                    RUN: begin
                        if (w_hi_hit || force_xoff) begin
                            state_q  <= REQ_XOFF;
                            tvalid_q <= 1'b1;
                            tdata_q  <= NFC_XOFF;
                        end
                    end
                    REQ_XOFF: begin
                        if (w_hs) begin
                            state_q  <= PAUSED;
                            tvalid_q <= 1'b0;
                            tdata_q  <= NFC_XON;
                            paused_q <= 1'b1;
                            timer_q  <= '0;
                            cnt_q    <= clr_stats ? 16'h0001 : w_cnt_inc;
                        end
                    end
                    PAUSED: begin
                        if (w_lo_hit && !force_xoff) begin
                            state_q  <= REQ_XON;
                            tvalid_q <= 1'b1;
                            tdata_q  <= NFC_XON;
                        end else if (w_refresh) begin
                            state_q  <= REQ_XOFF;
                            tvalid_q <= 1'b1;
                            tdata_q  <= NFC_XOFF;
                        end else begin
                            timer_q <= timer_q + TMR_W'(1);
                        end
                    end
                    REQ_XON: begin
                        if (w_hs) begin
                            state_q  <= RUN;
                            tvalid_q <= 1'b0;
                            paused_q <= 1'b0;
                        end
                    end
                    default: state_q <= LINK_DOWN;
                endcase
            end
        end
    end

    assign nfc_tvalid    = tvalid_q;
    assign nfc_tdata     = tdata_q;
    assign remote_paused = paused_q;
    assign xoff_cnt      = cnt_q;
    assign state_o       = state_q;

endmodule

`default_nettype wire

// File: tb/tb_aurora_nfc_ctrl.sv
// ============================================================================
// tb_aurora_nfc_ctrl: vector table, directed corner sequences and randomized
// traffic against a behavioural model of the NFC scheduler. Rev 1.0
// ============================================================================
`default_nettype none

module tb_aurora_nfc_ctrl;

    localparam int LVL_W  = 10;
    localparam int HI     = 384;
    localparam int LO     = 128;
    localparam int REFR   = 1024;

    logic             hs_clock;
    logic             pcie_reset_n;
    logic             cu;
    logic [LVL_W-1:0] lvl;
    logic             fx;
    logic             clr;
    logic             rdy;
    logic             nfc_tvalid;
    logic [7:0]       nfc_tdata;
    logic             remote_paused;
    logic [15:0]      xoff_cnt;
    logic [2:0]       state_o;

    int n_checks = 0;
    int n_errors = 0;

    aurora_nfc_ctrl dut (
        .hs_clock      (hs_clock),
        .pcie_reset_n  (pcie_reset_n),
        .channel_up    (cu),
        .fifo_level    (lvl),
        .force_xoff    (fx),
        .clr_stats     (clr),
        .nfc_tvalid    (nfc_tvalid),
        .nfc_tready    (rdy),
        .nfc_tdata     (nfc_tdata),
        .remote_paused (remote_paused),
        .xoff_cnt      (xoff_cnt),
        .state_o       (state_o)
    );

    initial begin
        hs_clock = 1'b0;
        forever #5 hs_clock = ~hs_clock;
    end

    // Behavioural model: link flag, pending request kind, pause flag, timer, count.
    bit m_link;
    int m_req;      // 0 none, 1 XOFF pending, 2 XON pending
    bit m_paused;
    int m_timer;
    int m_cnt;

    task automatic model_reset();
        m_link = 0; m_req = 0; m_paused = 0; m_timer = 0; m_cnt = 0;
    endtask

    task automatic model_step();
        int cnt_n;
        cnt_n = clr ? 0 : m_cnt;
        if (!cu) begin
            m_link = 0; m_req = 0; m_paused = 0; m_timer = 0;
        end else if (!m_link) begin
            m_link = 1;
        end else if (m_req == 1) begin
            if (rdy) begin
                m_req = 0; m_paused = 1; m_timer = 0;
                cnt_n = clr ? 1 : ((m_cnt + 1 > 65535) ? 65535 : m_cnt + 1);
            end
        end else if (m_req == 2) begin
            if (rdy) begin
                m_req = 0; m_paused = 0;
            end
        end else if (!m_paused) begin
            if (int'(lvl) >= HI || fx) m_req = 1;
        end else begin
            if (int'(lvl) <= LO && !fx) m_req = 2;
            else if (m_timer == REFR - 1) m_req = 1;
            else m_timer++;
        end
        m_cnt = cnt_n;
    endtask

    function automatic logic [2:0] model_state();
        if (!m_link)      return 3'd0;
        if (m_req == 1)   return 3'd2;
        if (m_req == 2)   return 3'd4;
        if (m_paused)     return 3'd3;
        return 3'd1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge hs_clock);
        #1;
    endtask

    task automatic do_reset();
        pcie_reset_n = 1'b0;
        cu = 0; lvl = '0; fx = 0; clr = 0; rdy = 0;
        repeat (3) @(posedge hs_clock);
        #1;
        model_reset();
        pcie_reset_n = 1'b1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".tvalid"}, 32'(nfc_tvalid), 32'(m_req != 0));
        chk({tag, ".tdata"},  32'(nfc_tdata),  (m_req == 1) ? 32'h10 : 32'h00);
        chk({tag, ".paused"}, 32'(remote_paused), 32'(m_paused));
        chk({tag, ".cnt"},    32'(xoff_cnt), 32'(m_cnt));
        chk({tag, ".state"},  32'(state_o), 32'(model_state()));
    endtask

    typedef struct {
        logic       cu, fx, clr, rdy;
        logic [9:0] lvl;
        logic       ev;
        logic [7:0] ed;
        logic       ep;
        logic [2:0] es;
        logic [15:0] ec;
    } vec_t;

    function automatic vec_t mk(input logic c, input int l, input logic f, input logic cl,
                                input logic r, input logic ev, input logic [7:0] ed,
                                input logic ep, input logic [2:0] es, input int ec);
        vec_t v;
        v.cu = c; v.lvl = 10'(l); v.fx = f; v.clr = cl; v.rdy = r;
        v.ev = ev; v.ed = ed; v.ep = ep; v.es = es; v.ec = 16'(ec);
        return v;
    endfunction

    initial begin
        vec_t vecs[19];
        int   hs_cyc[$];
        int   bad;
        bit   seen;

        //                cu  lvl fx clr rdy  ev  ed     ep es  ec
        vecs[0]  = mk(0,   0, 0, 0, 0,  0, 8'h00, 0, 0, 0);
        vecs[1]  = mk(1,   0, 0, 0, 0,  0, 8'h00, 0, 1, 0);
        vecs[2]  = mk(1,   0, 0, 0, 0,  0, 8'h00, 0, 1, 0);
        vecs[3]  = mk(1, 383, 0, 0, 0,  0, 8'h00, 0, 1, 0);
        vecs[4]  = mk(1, 384, 0, 0, 0,  1, 8'h10, 0, 2, 0);
        vecs[5]  = mk(1, 384, 0, 0, 0,  1, 8'h10, 0, 2, 0);
        vecs[6]  = mk(1,   0, 0, 0, 1,  0, 8'h00, 1, 3, 1);
        vecs[7]  = mk(1, 129, 0, 0, 1,  0, 8'h00, 1, 3, 1);
        vecs[8]  = mk(1, 128, 0, 0, 0,  1, 8'h00, 1, 4, 1);
        vecs[9]  = mk(1, 400, 0, 0, 0,  1, 8'h00, 1, 4, 1);
        vecs[10] = mk(1, 400, 0, 0, 1,  0, 8'h00, 0, 1, 1);
        vecs[11] = mk(1, 200, 0, 0, 1,  0, 8'h00, 0, 1, 1);
        vecs[12] = mk(1,   0, 1, 0, 1,  1, 8'h10, 0, 2, 1);
        vecs[13] = mk(1,   0, 1, 1, 1,  0, 8'h00, 1, 3, 1);
        vecs[14] = mk(1,   0, 1, 0, 1,  0, 8'h00, 1, 3, 1);
        vecs[15] = mk(1,   0, 0, 1, 0,  1, 8'h00, 1, 4, 0);
        vecs[16] = mk(0,   0, 0, 0, 0,  0, 8'h00, 0, 0, 0);
        vecs[17] = mk(1, 512, 0, 0, 0,  0, 8'h00, 0, 1, 0);
        vecs[18] = mk(1, 512, 0, 0, 0,  1, 8'h10, 0, 2, 0);

        do_reset();
        chk("rst.tvalid", 32'(nfc_tvalid), 32'h0);
        chk("rst.tdata",  32'(nfc_tdata), 32'h0);
        chk("rst.paused", 32'(remote_paused), 32'h0);
        chk("rst.cnt",    32'(xoff_cnt), 32'h0);
        chk("rst.state",  32'(state_o), 32'h0);

        for (int i = 0; i < 19; i++) begin
            cu = vecs[i].cu; lvl = vecs[i].lvl; fx = vecs[i].fx;
            clr = vecs[i].clr; rdy = vecs[i].rdy;
            tick();
            chk($sformatf("vec%0d.tvalid", i), 32'(nfc_tvalid), 32'(vecs[i].ev));
            chk($sformatf("vec%0d.tdata", i),  32'(nfc_tdata), 32'(vecs[i].ed));
            chk($sformatf("vec%0d.paused", i), 32'(remote_paused), 32'(vecs[i].ep));
            chk($sformatf("vec%0d.state", i),  32'(state_o), 32'(vecs[i].es));
            chk($sformatf("vec%0d.cnt", i),    32'(xoff_cnt), 32'(vecs[i].ec));
        end

        // Refresh: level held high, XOFF repeated every REFRESH_CYC+1 cycles.
        do_reset();
        cu = 1; lvl = 10'd400; rdy = 1;
        for (int c = 0; c < 3000; c++) begin
            if (nfc_tvalid && nfc_tdata == 8'h10) hs_cyc.push_back(c);
            tick();
        end
        chk("refresh.cnt", 32'(xoff_cnt), 32'd3);
        chk("refresh.n_hs", 32'(hs_cyc.size()), 32'd3);
        for (int k = 1; k < hs_cyc.size(); k++)
            chk($sformatf("refresh.gap%0d", k), 32'(hs_cyc[k] - hs_cyc[k-1]), 32'd1025);
        chk_model("refresh.model");

        // XOFF held without tready while the level collapses, then XON follows.
        do_reset();
        cu = 1; lvl = 10'd400; rdy = 0;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            seen = nfc_tvalid;
        end
        chk("hold.tvalid_seen", 32'(seen), 32'h1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            lvl = 10'(380 - 20 * i);
            tick();
            if (!nfc_tvalid || nfc_tdata != 8'h10) bad++;
        end
        chk("hold.violations", 32'(bad), 32'h0);
        rdy = 1;
        tick();
        chk("hold.accept_state", 32'(state_o), 32'd3);
        chk("hold.accept_paused", 32'(remote_paused), 32'h1);
        tick();
        chk("hold.xon_state", 32'(state_o), 32'd4);
        chk("hold.xon_tvalid", 32'(nfc_tvalid), 32'h1);
        chk("hold.xon_tdata", 32'(nfc_tdata), 32'h00);

        // Link loss in the middle of an unaccepted XON.
        rdy = 0;
        tick();
        chk("loss.pre_state", 32'(state_o), 32'd4);
        cu = 0;
        tick();
        chk("loss.tvalid", 32'(nfc_tvalid), 32'h0);
        chk("loss.paused", 32'(remote_paused), 32'h0);
        chk("loss.state", 32'(state_o), 32'd0);
        chk("loss.cnt", 32'(xoff_cnt), 32'd1);
        chk_model("loss.model");

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            cu  = ($urandom_range(0, 99) >= 2);
            case ($urandom_range(0, 2))
                0:       lvl = 10'($urandom_range(0, LO));
                1:       lvl = 10'($urandom_range(LO + 1, HI - 1));
                default: lvl = 10'($urandom_range(HI, 512));
            endcase
            fx  = ($urandom_range(0, 99) < 5);
            clr = ($urandom_range(0, 99) < 2);
            rdy = ($urandom_range(0, 99) < 70);
            tick();
            chk_model($sformatf("rand%0d", c));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
